pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the SCU ISA five-stage pipeline. It compares the source registers of the instruction in ID against the destinations in flight in the ID/EX and EX/MEM buffers, and stalls PC and IF/ID on a RAW hazard while inserting bubbles into ID/EX. The pipeline has no forwarding. On a taken branch or jump resolved out of EX/MEM, it flushes IF/ID and ID/EX for a programmable number of cycles. It drives the write-enable and flush inputs of the PC register and both front-end pipeline buffers.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: RAW stall, redirect flush, stall watchdog.
// Optional performance counters built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_MAX    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       id_rs,
  input  logic [5:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [5:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic [5:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             redirect,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned SL_W = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      flush_left_q, flush_left_d;
  logic [SL_W-1:0] stall_len_q, stall_len_d;
  logic            hazard_err_q, hazard_err_d;
  logic            err_set;
  logic            rs_hit, rt_hit, raw;

  // Register 0 is compared like any other address.
  assign rs_hit = (ex_regwrite && (id_rs == ex_rd)) || (mem_regwrite && (id_rs == mem_rd));
  assign rt_hit = (ex_regwrite && (id_rt == ex_rd)) || (mem_regwrite && (id_rt == mem_rd));
  assign raw    = (id_use_rs && rs_hit) || (id_use_rt && rt_hit);

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    stall_len_d  = stall_len_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      state_d      = RUN;
      flush_left_d = '0;
      stall_len_d  = '0;
    end else begin
      case (state_q)
        FLUSH: begin
          // flush_left counts remaining FLUSH-state cycles; leave when it hits 0
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          stall_len_d = '0;
          if (flush_left_q <= 2'd1) begin
            flush_left_d = '0;
            state_d      = RUN;
          end else begin
            flush_left_d = flush_left_q - 2'd1;
          end
        end
        default: begin
          if (redirect) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            stall_len_d  = '0;
            flush_left_d = 2'(FLUSH_CYCLES - 1);
            state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (raw) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = STALL;
            if (stall_len_q < SL_W'(STALL_MAX))
              stall_len_d = stall_len_q + SL_W'(1);
          end else begin
            state_d     = RUN;
            stall_len_d = '0;
          end
        end
      endcase
    end
  end

  // The error is visible in the same cycle the stall length reaches the limit.
  assign err_set      = reset && (stall_len_d == SL_W'(STALL_MAX));
  assign hazard_err_d = hazard_err_q || err_set;

  always_ff @(negedge clock) begin
    if (!reset) begin
      state_q      <= RUN;
      flush_left_q <= '0;
      stall_len_q  <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      stall_len_q  <= stall_len_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  assign state      = state_q;
  assign hazard_err = hazard_err_q || err_set;

`ifdef PIPE_HAZARD_PERF_EN
  logic             stall_take;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  assign stall_take = reset && (state_q != FLUSH) && !redirect && raw;

  always_ff @(negedge clock) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_take) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (idex_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl, plus hand-written counter/reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 16;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clock = 1'b1;
  logic             reset;
  logic [5:0]       id_rs, id_rt, ex_rd, mem_rd;
  logic             id_use_rs, id_use_rt, ex_regwrite, mem_regwrite, redirect;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, hazard_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(4), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .redirect(redirect),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state(state), .hazard_err(hazard_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [5:0] rs, rt;
    logic       urs, urt;
    logic [5:0] exrd;
    logic       exw;
    logic [5:0] memrd;
    logic       memw;
    logic       redir;
    logic [6:0] exp;   // {pc_write, ifid_write, ifid_flush, idex_flush, state[1:0], hazard_err}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [5:0] rs, input logic [5:0] rt,
                     input logic urs, input logic urt, input logic [5:0] exrd, input logic exw,
                     input logic [5:0] memrd, input logic memw, input logic redir,
                     input logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.exrd = exrd; v.exw = exw; v.memrd = memrd; v.memw = memw; v.redir = redir; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after posedge; outputs are then stable until the negedge commit.
  task automatic apply(input vec_t v);
    @(posedge clock);
    reset = v.rst; id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
    ex_rd = v.exrd; ex_regwrite = v.exw; mem_rd = v.memrd; mem_regwrite = v.memw; redirect = v.redir;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_flush, state, hazard_err};
  endfunction

  function automatic logic [31:0] cexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  function automatic vec_t mk(input logic rst, input logic [5:0] rs, input logic urs,
                              input logic [5:0] exrd, input logic exw,
                              input logic [5:0] memrd, input logic memw, input logic redir);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = 6'd0; v.urs = urs; v.urt = 1'b0;
    v.exrd = exrd; v.exw = exw; v.memrd = memrd; v.memw = memw; v.redir = redir; v.exp = '0;
    return v;
  endfunction

  initial begin
    vec_t idle, rawex, rawmem, redir, redraw;
    reset = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = '0; ex_regwrite = 1'b0; mem_rd = '0; mem_regwrite = 1'b0; redirect = 1'b1;

    //   rst rs    rt    urs urt exrd  exw memrd memw red  pc_if_iff_idf_st_err
    // reset held with redirect=1, then release
    add(0, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 1, 7'b0011_00_0);
    add(0, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 1, 7'b0011_00_0);
    add(0, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 1, 7'b0011_00_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_00_0);
    // ID/EX producer advancing to EX/MEM: two stall cycles
    add(1, 6'd5, 6'd0, 1, 0, 6'd5, 1, 6'd0, 0, 0, 7'b0001_00_0);
    add(1, 6'd5, 6'd0, 1, 0, 6'd0, 0, 6'd5, 1, 0, 7'b0001_01_0);
    add(1, 6'd5, 6'd0, 1, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_01_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_00_0);
    // single redirect: exactly two flush cycles
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 1, 7'b1111_00_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1111_10_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_00_0);
    // redirect repeated inside FLUSH does not extend it
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 1, 7'b1111_00_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 1, 7'b1111_10_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_00_0);
    // redirect with raw: flush wins; raw on last FLUSH cycle ignored, then stalls in RUN
    add(1, 6'd5, 6'd0, 1, 0, 6'd5, 1, 6'd0, 0, 1, 7'b1111_00_0);
    add(1, 6'd5, 6'd0, 1, 0, 6'd5, 1, 6'd0, 0, 0, 7'b1111_10_0);
    add(1, 6'd5, 6'd0, 1, 0, 6'd5, 1, 6'd0, 0, 0, 7'b0001_00_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_01_0);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_00_0);
    // watchdog: raw on rt for 6 cycles, error on the 4th and sticky afterwards
    add(1, 6'd0, 6'd9, 0, 1, 6'd0, 0, 6'd9, 1, 0, 7'b0001_00_0);
    add(1, 6'd0, 6'd9, 0, 1, 6'd0, 0, 6'd9, 1, 0, 7'b0001_01_0);
    add(1, 6'd0, 6'd9, 0, 1, 6'd0, 0, 6'd9, 1, 0, 7'b0001_01_0);
    add(1, 6'd0, 6'd9, 0, 1, 6'd0, 0, 6'd9, 1, 0, 7'b0001_01_1);
    add(1, 6'd0, 6'd9, 0, 1, 6'd0, 0, 6'd9, 1, 0, 7'b0001_01_1);
    add(1, 6'd0, 6'd9, 0, 1, 6'd0, 0, 6'd9, 1, 0, 7'b0001_01_1);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_01_1);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_00_1);
    // masking by use flag and by regwrite; register 0 still compared
    add(1, 6'd5, 6'd0, 0, 0, 6'd5, 1, 6'd0, 0, 0, 7'b1100_00_1);
    add(1, 6'd5, 6'd0, 1, 0, 6'd5, 0, 6'd0, 0, 0, 7'b1100_00_1);
    add(1, 6'd0, 6'd0, 0, 1, 6'd0, 0, 6'd0, 1, 0, 7'b0001_00_1);
    // reset mid-STALL abandons it and clears the error
    add(0, 6'd0, 6'd0, 0, 1, 6'd0, 0, 6'd0, 1, 0, 7'b0011_01_1);
    add(1, 6'd0, 6'd0, 0, 0, 6'd0, 0, 6'd0, 0, 0, 7'b1100_00_0);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Counter and reset-mid-FLUSH sequences
    idle   = mk(1, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0);
    rawex  = mk(1, 6'd5, 1, 6'd5, 1, 6'd0, 0, 0);
    rawmem = mk(1, 6'd5, 1, 6'd0, 0, 6'd5, 1, 0);
    redir  = mk(1, 6'd0, 0, 6'd0, 0, 6'd0, 0, 1);
    redraw = mk(1, 6'd5, 1, 6'd5, 1, 6'd0, 0, 1);

    apply(mk(0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0));
    apply(idle);
    chk("cnt_reset_stall", 32'(stall_count), 32'd0);
    chk("cnt_reset_flush", 32'(flush_count), 32'd0);

    apply(rawex); apply(rawmem); apply(mk(1, 6'd5, 1, 6'd0, 0, 6'd0, 0, 0)); apply(idle);
    chk("cnt_prod_stall", 32'(stall_count), cexp(2));
    chk("cnt_prod_flush", 32'(flush_count), cexp(2));

    apply(redir); apply(idle); apply(idle);
    chk("cnt_redir_out", 32'(outs()), 32'(7'b1100_00_0));
    chk("cnt_redir_stall", 32'(stall_count), cexp(2));
    chk("cnt_redir_flush", 32'(flush_count), cexp(4));

    apply(redraw); apply(rawex); apply(rawex);
    chk("cnt_prio_out", 32'(outs()), 32'(7'b0001_00_0));
    chk("cnt_prio_stall", 32'(stall_count), cexp(2));
    chk("cnt_prio_flush", 32'(flush_count), cexp(6));
    apply(idle);
    chk("cnt_after_stall", 32'(stall_count), cexp(3));
    chk("cnt_after_flush", 32'(flush_count), cexp(7));

    apply(redir);
    apply(mk(0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0));
    chk("rst_mid_flush_out", 32'(outs()), 32'(7'b0011_10_0));
    apply(idle);
    chk("rst_first_run", 32'(outs()), 32'(7'b1100_00_0));
    chk("rst_cnt_stall", 32'(stall_count), 32'd0);
    chk("rst_cnt_flush", 32'(flush_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
